tz_glyph_streamer: RTL and testbench

Fetches one 32×32 timezone-label glyph from the TZ glyph ROM, row by row, and serializes it into a valid/ready pixel stream for the display write stage. It sits directly downstream of the TZ ROM: it drives the ROM's enable, output-register enable and address, and consumes its 32-bit row data. A single `start` pulse selects one of four glyphs and streams exactly 1024 pixels, MSB-first within each row, top row first.

---
 rtl/tz_pkg.sv | 24 ++
 rtl/tz_row_shifter.sv | 62 ++++++
 rtl/tz_glyph_streamer.sv | 155 +++++++++++++++
 tb/tb_tz_glyph_streamer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tz_pkg.sv
// ----------------------------------------------------------------------------
// tz_pkg
// Shared constants and types for the TZ glyph streaming path: ROM geometry,
// the streamer FSM state encoding and the glyph index type.
// ----------------------------------------------------------------------------
package tz_pkg;

  localparam int TZ_GLYPHS = 4;   // glyphs stored in the TZ ROM
  localparam int TZ_ROWS   = 32;  // rows per glyph, pixels per row
  localparam int TZ_ADDR_W = 7;   // log2(TZ_GLYPHS * TZ_ROWS)
  localparam int TZ_DATA_W = 32;  // one ROM word holds one glyph row

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SHIFT   = 3'd4,
    ST_DONE    = 3'd5
  } tz_stream_state_t;

  typedef logic [1:0] tz_glyph_t;

endpackage

// File: rtl/tz_row_shifter.sv
// ----------------------------------------------------------------------------
// tz_row_shifter
// Holds one glyph row and presents it one pixel at a time, MSB first.
//   load      : capture data_in and restart at column 0
//   advance   : move to the next pixel (ignored when load is high)
//   shift_bit : current pixel, taken straight from the register MSB
//   col       : current column
//   last_col  : col is the final column of the row
// The column counter stops at the last column; only load returns it to 0.
// ----------------------------------------------------------------------------
module tz_row_shifter
  import tz_pkg::*;
#(
  parameter int DATA_W = TZ_DATA_W,
  parameter int COL_W  = $clog2(TZ_DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] data_in,
  output logic              shift_bit,
  output logic [COL_W-1:0]  col,
  output logic              last_col
);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [COL_W-1:0]  col_q, col_d;

  assign last_col  = (col_q == COL_W'(DATA_W - 1));
  assign shift_bit = shreg_q[DATA_W-1];
  assign col       = col_q;

  always_comb begin
    // NOTE: every signal gets a hold default first, so no branch can leave it
    // unassigned and infer a latch.
    shreg_d = shreg_q;
    col_d   = col_q;
    if (load) begin
      shreg_d = data_in;
      col_d   = '0;
    end else if (advance) begin
      // Shifting left keeps the pixel for col on the register MSB, so the
      // pixel output is a flop rather than a 32:1 mux.
      shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
      if (!last_col) col_d = col_q + COL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      col_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge
      // values regardless of statement order.
      shreg_q <= shreg_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: rtl/tz_glyph_streamer.sv
// ----------------------------------------------------------------------------
// tz_glyph_streamer
// Reads one 32x32 glyph from the TZ ROM row by row and emits it as a
// valid/ready pixel stream, top row first, MSB first within a row.
//   clk, rst           : clock (also the ROM clock), async active-high reset
//   start, tz_sel      : request pulse and glyph index, sampled in IDLE only
//   busy, done         : transfer in progress / one-cycle completion pulse
//   rom_en, rom_regce  : ROM read enable / ROM output-register enable
//   rom_addr, rom_data : {glyph,row} address / row word (2-cycle latency)
//   px_valid, px_ready : pixel handshake
//   px_data, px_x,
//   px_y, px_last      : pixel value, column, row, final-pixel flag
// Every output comes from a flop. Registered outputs are computed from the
// next state, so they line up with the state register with no extra latency.
// ----------------------------------------------------------------------------
module tz_glyph_streamer
  import tz_pkg::*;
#(
  parameter int GLYPHS = TZ_GLYPHS,
  parameter int ROWS   = TZ_ROWS,
  parameter int ADDR_W = TZ_ADDR_W,
  parameter int DATA_W = TZ_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  tz_glyph_t                tz_sel,
  output logic                     busy,
  output logic                     done,
  output logic                     rom_en,
  output logic                     rom_regce,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     px_valid,
  input  logic                     px_ready,
  output logic                     px_data,
  output logic [$clog2(ROWS)-1:0]  px_x,
  output logic [$clog2(ROWS)-1:0]  px_y,
  output logic                     px_last
);

  localparam int GW = $clog2(GLYPHS);
  localparam int RW = $clog2(ROWS);

  tz_stream_state_t state_q, state_d;
  logic [GW-1:0]     glyph_q, glyph_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic busy_q, busy_d, done_q, done_d;
  logic rom_en_q, rom_en_d, rom_regce_q, rom_regce_d;
  logic px_valid_q, px_valid_d, px_last_q, px_last_d;

  logic          hs;
  logic          last_row;
  logic          last_col;
  logic [RW-1:0] col;

  assign hs       = px_valid_q & px_ready;
  assign last_row = (row_q == RW'(ROWS - 1));

  tz_row_shifter #(
    .DATA_W (DATA_W),
    .COL_W  (RW)
  ) u_row_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (state_q == ST_CAPTURE),
    .advance   (hs),
    .data_in   (rom_data),
    .shift_bit (px_data),
    .col       (col),
    .last_col  (last_col)
  );

  always_comb begin
    state_d = state_q;
    glyph_d = glyph_q;
    row_d   = row_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          glyph_d = tz_sel[GW-1:0];
          row_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH:   state_d = ST_WAIT;
      ST_WAIT:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (hs && last_col) begin
          if (last_row) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    rom_en_d    = (state_d == ST_FETCH);
    rom_regce_d = (state_d == ST_WAIT);
    px_valid_d  = (state_d == ST_SHIFT);
    // The address is a plain concatenation and changes only on entry to FETCH.
    rom_addr_d  = (state_d == ST_FETCH) ? {glyph_d, row_d} : rom_addr_q;
    // Predict the column the shifter will show next cycle. Only a cycle that
    // is already in SHIFT counts: on entry col still holds the previous row's
    // final column.
    px_last_d   = (state_q == ST_SHIFT) && (state_d == ST_SHIFT) && last_row &&
                  (hs ? (col == RW'(ROWS - 2)) : last_col);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      glyph_q     <= '0;
      row_q       <= '0;
      rom_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_regce_q <= 1'b0;
      px_valid_q  <= 1'b0;
      px_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      glyph_q     <= glyph_d;
      row_q       <= row_d;
      rom_addr_q  <= rom_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rom_en_q    <= rom_en_d;
      rom_regce_q <= rom_regce_d;
      px_valid_q  <= px_valid_d;
      px_last_q   <= px_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_en    = rom_en_q;
  assign rom_regce = rom_regce_q;
  assign rom_addr  = rom_addr_q;
  assign px_valid  = px_valid_q;
  assign px_x      = col;
  assign px_y      = row_q;
  assign px_last   = px_last_q;

endmodule

// File: tb/tb_tz_glyph_streamer.sv
// ----------------------------------------------------------------------------
// tb_tz_glyph_streamer
// Directed bench for tz_glyph_streamer with a behavioural 2-cycle TZ ROM.
// Inputs change and outputs are sampled on the falling edge; the observation
// index c counts rising edges since the one that sampled start, so an output
// seen at c is the value the next rising edge (edge c) will sample.
// ----------------------------------------------------------------------------
module tb_tz_glyph_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  tz_sel;
  logic        busy, done, rom_en, rom_regce;
  logic [6:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] rom_q    = '0;
  logic        px_valid, px_ready, px_data, px_last;
  logic [4:0]  px_x, px_y;
  logic [23:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tz_glyph_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tz_sel    (tz_sel),
    .busy      (busy),
    .done      (done),
    .rom_en    (rom_en),
    .rom_regce (rom_regce),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_data   (px_data),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_last   (px_last)
  );

  assign outs = {busy, done, rom_en, rom_regce, rom_addr, px_valid,
                 px_data, px_x, px_y, px_last};

  // ROM contents: a recognisable pattern built from {glyph,row}.
  function automatic logic [31:0] rom_word(input logic [6:0] a);
    return {a, ~a, a, ~a, 4'b1001};
  endfunction

  // Address register on rom_en, output register on rom_regce.
  always @(posedge clk) begin
    if (rom_en)    rom_q    <= rom_word(rom_addr);
    if (rom_regce) rom_data <= rom_q;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Streams glyph g from a falling edge. bp enables the 1,0,0 ready pattern;
  // spur_at (>0) raises a start with tz_sel=3 at that observation index.
  // Returns one cycle after done, at a falling edge, with the DUT idle.
  task automatic stream(input logic [1:0] g, input bit bp, input int spur_at);
    int c       = 0;
    int n_fetch = 0;
    int n_pix   = 0;
    int stalls  = 0;
    int first_v = -1;
    int done_c  = -1;
    int x, y;
    logic [31:0] w;
    start    = 1'b1;
    tz_sel   = g;
    px_ready = 1'b1;
    while (done_c < 0 && c < 5000) begin
      @(negedge clk);
      c++;
      start  = (c == spur_at);
      tz_sel = (c == spur_at) ? 2'd3 : g;
      check("busy", busy, 1);
      if (rom_en) begin
        check("rom_addr", rom_addr, {g, n_fetch[4:0]});
        n_fetch++;
      end
      px_ready = bp ? (c % 3 == 0) : 1'b1;
      if (px_valid) begin
        if (first_v < 0) first_v = c;
        y = n_pix / 32;
        x = n_pix % 32;
        w = rom_word({g, y[4:0]});
        check("px_x", px_x, x);
        check("px_y", px_y, y);
        check("px_data", px_data, w[31-x]);
        check("px_last", px_last, (n_pix == 1023));
        if (px_ready) n_pix++;
        else          stalls++;
      end else begin
        check("px_last_idle", px_last, 0);
      end
      if (done) done_c = c;
    end
    check("timeout", (done_c >= 0), 1);
    check("fetches", n_fetch, 32);
    check("pixels", n_pix, 1024);
    check("first_valid", first_v, 4);
    check("done_cycle", done_c, 1121 + stalls);
    @(negedge clk);
    start = 1'b0;
    check("busy_after", busy, 0);
    check("done_pulse", done, 0);
  endtask

  initial begin
    int cnt;
    rst      = 1'b1;
    start    = 1'b0;
    tz_sel   = 2'd0;
    px_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs, 0);
    rst = 1'b0;

    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (rom_en || busy || px_valid || done) cnt++;
    end
    check("idle_quiet", cnt, 0);
    check("idle_outs", outs, 0);

    stream(2'd2, 1'b0, 0);     // full glyph, ready always high
    stream(2'd1, 1'b0, 0);     // back-to-back start the cycle after done
    stream(2'd2, 1'b0, 500);   // start while busy is ignored
    stream(2'd3, 1'b1, 0);     // backpressure 1,0,0

    // Reset in the middle of a transfer.
    start    = 1'b1;
    tz_sel   = 2'd2;
    px_ready = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_outs", outs, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy || rom_en || px_valid) cnt++;
    end
    check("midrst_quiet", cnt, 0);
    stream(2'd0, 1'b0, 0);     // restart streams glyph 0 from (0,0)

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
